arcade_input_mapper: RTL and testbench

- Parametrised input front end for arcade cores; replaces the per-core ad-hoc keyboard and joystick glue.
- Merges PS/2 key events and up to 4 MiSTer joysticks into registered, active-high per-player control vectors.
- Supports vertical-screen rotation in either direction.
- Generates timed, debounced coin pulses per player. Sits between hps_io and the core's input registers; the core applies its own inversion.

---
 rtl/arcade_input_pkg.sv | 136 +++++++++++++
 rtl/arcade_coin_pulse.sv | 68 ++++++
 rtl/arcade_input_mapper.sv | 133 +++++++++++++
 tb/tb_arcade_input_mapper.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end: joystick/ctrl bit positions,
// PS/2 set-2 key codes, key-latch indices and the coin pulse state type.
package arcade_input_pkg;

    // MiSTer joystick word bit positions
    localparam int J_RIGHT    = 0;
    localparam int J_LEFT     = 1;
    localparam int J_DOWN     = 2;
    localparam int J_UP       = 3;
    localparam int J_FIRE1    = 4;
    localparam int J_START    = 5;
    localparam int J_COIN     = 6;
    localparam int J_FIRE2    = 7;
    localparam int J_FIRE3    = 8;
    localparam int J_AUTOFIRE = 9;

    // Per-player ctrl byte: {0, fire3, fire2, fire1, right, left, down, up}
    localparam int C_UP    = 0;
    localparam int C_DOWN  = 1;
    localparam int C_LEFT  = 2;
    localparam int C_RIGHT = 3;
    localparam int C_FIRE1 = 4;
    localparam int C_FIRE2 = 5;
    localparam int C_FIRE3 = 6;

    // Arrow keys compare only the low byte, so E0-prefixed and keypad forms both match.
    localparam logic [7:0] KC_ARROW_UP    = 8'h75;
    localparam logic [7:0] KC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] KC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] KC_ARROW_RIGHT = 8'h74;

    localparam logic [8:0] KC_SPACE  = 9'h029;
    localparam logic [8:0] KC_CTRL   = 9'h014;
    localparam logic [8:0] KC_ALT    = 9'h011;
    localparam logic [8:0] KC_F1     = 9'h005;
    localparam logic [8:0] KC_1      = 9'h016;
    localparam logic [8:0] KC_F2     = 9'h006;
    localparam logic [8:0] KC_2      = 9'h01E;
    localparam logic [8:0] KC_3      = 9'h026;
    localparam logic [8:0] KC_4      = 9'h025;
    localparam logic [8:0] KC_COIN1  = 9'h02E;
    localparam logic [8:0] KC_COIN2  = 9'h036;
    localparam logic [8:0] KC_COIN3  = 9'h03D;
    localparam logic [8:0] KC_COIN4  = 9'h03E;
    localparam logic [8:0] KC_P2_UP  = 9'h02D;
    localparam logic [8:0] KC_P2_DN  = 9'h02B;
    localparam logic [8:0] KC_P2_LT  = 9'h023;
    localparam logic [8:0] KC_P2_RT  = 9'h034;
    localparam logic [8:0] KC_P2_F1  = 9'h01C;
    localparam logic [8:0] KC_P2_F2  = 9'h01B;
    localparam logic [8:0] KC_TEST   = 9'h02C;

    // One latch per physical key so that overlapping keys on one function stay independent.
    localparam int K_UP     = 0;
    localparam int K_DOWN   = 1;
    localparam int K_LEFT   = 2;
    localparam int K_RIGHT  = 3;
    localparam int K_SPACE  = 4;
    localparam int K_CTRL   = 5;
    localparam int K_ALT    = 6;
    localparam int K_F1     = 7;
    localparam int K_1      = 8;
    localparam int K_F2     = 9;
    localparam int K_2      = 10;
    localparam int K_3      = 11;
    localparam int K_4      = 12;
    localparam int K_COIN1  = 13;
    localparam int K_COIN2  = 14;
    localparam int K_COIN3  = 15;
    localparam int K_COIN4  = 16;
    localparam int K_P2_UP  = 17;
    localparam int K_P2_DN  = 18;
    localparam int K_P2_LT  = 19;
    localparam int K_P2_RT  = 20;
    localparam int K_P2_F1  = 21;
    localparam int K_P2_F2  = 22;
    localparam int K_TEST   = 23;
    localparam int KEY_N    = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // One-hot key-latch select for a PS/2 code; unknown codes give all zeros.
    function automatic logic [KEY_N-1:0] key_decode(input logic [8:0] code);
        logic [KEY_N-1:0] hit;
        hit          = '0;
        hit[K_UP]    = (code[7:0] == KC_ARROW_UP);
        hit[K_DOWN]  = (code[7:0] == KC_ARROW_DOWN);
        hit[K_LEFT]  = (code[7:0] == KC_ARROW_LEFT);
        hit[K_RIGHT] = (code[7:0] == KC_ARROW_RIGHT);
        hit[K_SPACE] = (code == KC_SPACE);
        hit[K_CTRL]  = (code == KC_CTRL);
        hit[K_ALT]   = (code == KC_ALT);
        hit[K_F1]    = (code == KC_F1);
        hit[K_1]     = (code == KC_1);
        hit[K_F2]    = (code == KC_F2);
        hit[K_2]     = (code == KC_2);
        hit[K_3]     = (code == KC_3);
        hit[K_4]     = (code == KC_4);
        hit[K_COIN1] = (code == KC_COIN1);
        hit[K_COIN2] = (code == KC_COIN2);
        hit[K_COIN3] = (code == KC_COIN3);
        hit[K_COIN4] = (code == KC_COIN4);
        hit[K_P2_UP] = (code == KC_P2_UP);
        hit[K_P2_DN] = (code == KC_P2_DN);
        hit[K_P2_LT] = (code == KC_P2_LT);
        hit[K_P2_RT] = (code == KC_P2_RT);
        hit[K_P2_F1] = (code == KC_P2_F1);
        hit[K_P2_F2] = (code == KC_P2_F2);
        hit[K_TEST]  = (code == KC_TEST);
        return hit;
    endfunction

    // raw/return order is {right, left, down, up}; ccw selects the rotation direction.
    function automatic logic [3:0] rotate_dirs(input logic [3:0] raw, input logic rot,
                                               input logic ccw);
        logic [3:0] o;
        o = raw;
        if (rot && !ccw) begin
            o[C_UP]    = raw[C_LEFT];
            o[C_DOWN]  = raw[C_RIGHT];
            o[C_LEFT]  = raw[C_DOWN];
            o[C_RIGHT] = raw[C_UP];
        end else if (rot) begin
            o[C_UP]    = raw[C_RIGHT];
            o[C_DOWN]  = raw[C_LEFT];
            o[C_LEFT]  = raw[C_UP];
            o[C_RIGHT] = raw[C_DOWN];
        end
        return o;
    endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// Edge-triggered coin pulse: COIN_PULSE_CYC cycles high, then at least
// COIN_PULSE_CYC cycles low; edges arriving while busy are dropped.
module arcade_coin_pulse
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE_CYC = 2400000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic src,
    output logic coin
);

    localparam int CW = $clog2(COIN_PULSE_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(COIN_PULSE_CYC - 1);

    coin_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          src_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            src_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            src_q <= src;
        end
    end

    // src_q tracks the source in every state, so a source held across the gap never retriggers.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (src && !src_q) begin
                    state_nxt = PULSE;
                    cnt_nxt   = RELOAD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = RELOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign coin = (state == PULSE);

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and MiSTer joysticks into registered per-player controls with
// rotation and coin pulses. Optional autofire: define ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS        = 2,
    parameter int COIN_PULSE_CYC = 2400000,
    parameter int AUTOFIRE_CYC   = 1200000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [16*PLAYERS-1:0]  joy,
    input  logic                   rotate,
    input  logic                   rot_ccw,
    input  logic                   start_coin,
    output logic [8*PLAYERS-1:0]   ctrl,
    output logic [PLAYERS-1:0]     start,
    output logic [PLAYERS-1:0]     coin,
    output logic                   test
);

    logic             tog_q;
    logic             primed;
    logic             key_event;
    logic [KEY_N-1:0] key_hit;
    logic [KEY_N-1:0] key_lat;

    logic [63:0]      joy_all;
    logic [3:0]       kb_up, kb_down, kb_left, kb_right, kb_f1, kb_f2, kb_start, kb_coin;
    logic [31:0]      ctrl_all_nxt;
    logic [3:0]       start_all_nxt;
    logic [3:0]       coin_src;
    logic             af_phase;

    // The first clock after reset only primes the toggle copy, so a stale toggle is not an event.
    assign key_event = primed && (ps2_key[10] != tog_q);
    assign key_hit   = key_decode(ps2_key[8:0]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            primed  <= 1'b0;
            key_lat <= '0;
        end else begin
            tog_q  <= ps2_key[10];
            primed <= 1'b1;
            if (key_event) begin
                key_lat <= (key_lat & ~key_hit) | (key_hit & {KEY_N{ps2_key[9]}});
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_CYC + 1);
    logic [AW-1:0] af_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == AW'(AUTOFIRE_CYC - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end
`else
    assign af_phase = 1'b0;
`endif

    // Players are handled as a fixed 4-slot array; slots >= PLAYERS are computed then dropped.
    assign joy_all  = 64'(joy);
    assign kb_up    = {2'b00, key_lat[K_P2_UP], key_lat[K_UP]};
    assign kb_down  = {2'b00, key_lat[K_P2_DN], key_lat[K_DOWN]};
    assign kb_left  = {2'b00, key_lat[K_P2_LT], key_lat[K_LEFT]};
    assign kb_right = {2'b00, key_lat[K_P2_RT], key_lat[K_RIGHT]};
    assign kb_f1    = {2'b00, key_lat[K_P2_F1], key_lat[K_SPACE] | key_lat[K_CTRL]};
    assign kb_f2    = {2'b00, key_lat[K_P2_F2], key_lat[K_ALT]};
    assign kb_start = {key_lat[K_4], key_lat[K_3], key_lat[K_F2] | key_lat[K_2],
                       key_lat[K_F1] | key_lat[K_1]};
    assign kb_coin  = {key_lat[K_COIN4], key_lat[K_COIN3], key_lat[K_COIN2], key_lat[K_COIN1]};

    always_comb begin
        ctrl_all_nxt  = '0;
        start_all_nxt = '0;
        coin_src      = '0;
        for (int p = 0; p < 4; p++) begin
            logic [15:0] jp;
            logic [3:0]  raw;
            logic        m_f1;
            jp  = joy_all[16*p +: 16];
            raw[C_UP]    = kb_up[p]    | jp[J_UP];
            raw[C_DOWN]  = kb_down[p]  | jp[J_DOWN];
            raw[C_LEFT]  = kb_left[p]  | jp[J_LEFT];
            raw[C_RIGHT] = kb_right[p] | jp[J_RIGHT];
            m_f1 = kb_f1[p] | jp[J_FIRE1] | (jp[J_AUTOFIRE] & af_phase);
            ctrl_all_nxt[8*p +: 8] = {1'b0, jp[J_FIRE3], kb_f2[p] | jp[J_FIRE2], m_f1,
                                      rotate_dirs(raw, rotate, rot_ccw)};
            start_all_nxt[p] = kb_start[p] | jp[J_START];
            coin_src[p]      = kb_coin[p] | jp[J_COIN] | (start_coin & start_all_nxt[p]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctrl  <= '0;
            start <= '0;
            test  <= 1'b0;
        end else begin
            ctrl  <= ctrl_all_nxt[8*PLAYERS-1:0];
            start <= start_all_nxt[PLAYERS-1:0];
            test  <= key_lat[K_TEST];
        end
    end

    for (genvar g = 0; g < PLAYERS; g++) begin : g_coin
        arcade_coin_pulse #(
            .COIN_PULSE_CYC(COIN_PULSE_CYC)
        ) u_coin (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .src    (coin_src[g]),
            .coin   (coin[g])
        );
    end

    // Joystick bits 10-15, and slots beyond PLAYERS, have no destination.
    logic unused_bits;
    assign unused_bits = ^{joy_all, ctrl_all_nxt, start_all_nxt, coin_src};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed checks plus randomized stimulus scored
// against a key-set / pulse-window model; ARCADE_INPUT_AUTOFIRE_EN adds autofire checks.
module tb_arcade_input_mapper;

    localparam int P  = 2;
    localparam int CP = 4;
    localparam int AF = 3;
    localparam int W  = 8*P + P + P + 1;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic [10:0]     ps2_key = '0;
    logic [16*P-1:0] joy = '0;
    logic            rotate = 1'b0;
    logic            rot_ccw = 1'b0;
    logic            start_coin = 1'b0;
    logic [8*P-1:0]  ctrl;
    logic [P-1:0]    start;
    logic [P-1:0]    coin;
    logic            test;

    int vectors = 0;
    int miscompares = 0;

    arcade_input_mapper #(
        .PLAYERS(P), .COIN_PULSE_CYC(CP), .AUTOFIRE_CYC(AF)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
        .rotate(rotate), .rot_ccw(rot_ccw), .start_coin(start_coin),
        .ctrl(ctrl), .start(start), .coin(coin), .test(test)
    );

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    bit             kd [512];
    int             n_edge;
    logic           tog_prev;
    bit             src_prev [P];
    int             p_start [P];
    int             p_ready [P];
    logic [W-1:0]   exp_q [$];
    logic [W-1:0]   sb_exp;

    function automatic logic [8:0] norm(input logic [8:0] c);
        logic [7:0] lo;
        lo = c[7:0];
        if (lo == 8'h75 || lo == 8'h72 || lo == 8'h6B || lo == 8'h74) return {1'b1, lo};
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 512; i++) kd[i] = 1'b0;
        n_edge = 0;
        tog_prev = 1'b0;
        for (int p = 0; p < P; p++) begin
            src_prev[p] = 1'b0;
            p_start[p]  = -1000;
            p_ready[p]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic [15:0]    j;
        bit             u, d, l, r, f1, f2, f3, st, cn, src;
        bit             ru, rd, rl, rr;
        logic [8*P-1:0] e_ctrl;
        logic [P-1:0]   e_start, e_coin;
        n_edge++;
        for (int p = 0; p < P; p++) begin
            j = joy[16*p +: 16];
            if (p == 0) begin
                u = kd[9'h175]; d = kd[9'h172]; l = kd[9'h16B]; r = kd[9'h174];
                f1 = kd[9'h029] | kd[9'h014]; f2 = kd[9'h011];
                st = kd[9'h005] | kd[9'h016]; cn = kd[9'h02E];
            end else begin
                u = kd[9'h02D]; d = kd[9'h02B]; l = kd[9'h023]; r = kd[9'h034];
                f1 = kd[9'h01C]; f2 = kd[9'h01B];
                st = kd[9'h006] | kd[9'h01E]; cn = kd[9'h036];
            end
            u |= j[3]; d |= j[2]; l |= j[1]; r |= j[0];
            f1 |= j[4]; f2 |= j[7]; f3 = j[8]; st |= j[5]; cn |= j[6];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            if (j[9] && (((n_edge - 1) / AF) % 2 == 1)) f1 = 1'b1;
`endif
            if (!rotate)      begin ru = u; rd = d; rl = l; rr = r; end
            else if (!rot_ccw) begin ru = l; rd = r; rl = d; rr = u; end
            else              begin ru = r; rd = l; rl = u; rr = d; end
            e_ctrl[8*p +: 8] = {1'b0, f3, f2, f1, rr, rl, rd, ru};
            e_start[p] = st;
            src = cn | (start_coin & st);
            if (src && !src_prev[p] && n_edge >= p_ready[p]) begin
                p_start[p] = n_edge;
                p_ready[p] = n_edge + 2*CP + 1;
            end
            src_prev[p] = src;
            e_coin[p] = (n_edge - p_start[p]) < CP;
        end
        exp_q.push_back({e_ctrl, e_start, e_coin, logic'(kd[9'h02C])});
        if (n_edge >= 2 && ps2_key[10] != tog_prev) kd[norm(ps2_key[8:0])] = ps2_key[9];
        tog_prev = ps2_key[10];
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_edge();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk_sys) begin
        if (reset_n && exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            vectors++;
            if ({ctrl, start, coin, test} !== sb_exp) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: {ctrl,start,coin,test} got %h required %h",
                         $time, {ctrl, start, coin, test}, sb_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic key(input logic pressed, input logic [8:0] code);
        @(posedge clk_sys);
        #2;
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic wait_coin(input int p, input logic lvl);
        int k;
        k = 0;
        @(negedge clk_sys);
        while (coin[p] !== lvl && k < 40) begin
            @(negedge clk_sys);
            k++;
        end
        if (coin[p] !== lvl) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_coin%0d: got %b required %b within 40 cycles", p, coin[p], lvl);
        end
    endtask

    task automatic count_coin(input int p, input int n, output int highs, output int rises);
        logic prv;
        highs = 0;
        rises = 0;
        prv = coin[p];
        repeat (n) begin
            @(negedge clk_sys);
            if (coin[p] === 1'b1) highs++;
            if (coin[p] === 1'b1 && prv !== 1'b1) rises++;
            prv = coin[p];
        end
    endtask

    logic [8:0] codes [27] = '{9'h175, 9'h075, 9'h172, 9'h06B, 9'h174, 9'h029, 9'h014,
                               9'h011, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h026, 9'h025,
                               9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h02D, 9'h02B, 9'h023,
                               9'h034, 9'h01C, 9'h01B, 9'h02C, 9'h0AA, 9'h11E};

    // ---------------- stimulus ----------------
    initial begin
        int  hi, rs;
        bit  seen;
        // A pressed key held across reset release must not produce an event.
        ps2_key = {1'b1, 1'b1, 9'h029};
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("stale_toggle_fire1", 32'(ctrl[4]), 32'd0);
        check("reset_state_coin", 32'(coin), 32'd0);

        // Up arrow latency: visible after the second edge following the toggle.
        key(1'b1, 9'h175);
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("up_lat_1cyc", 32'(ctrl[0]), 32'd0);
        @(negedge clk_sys);
        check("up_lat_2cyc", 32'(ctrl[0]), 32'd1);
        key(1'b0, 9'h175);
        tick(3);
        check("up_release", 32'(ctrl[0]), 32'd0);

        // Two keys on one function.
        key(1'b1, 9'h029);
        key(1'b1, 9'h014);
        key(1'b0, 9'h029);
        tick(3);
        check("fire1_held_by_ctrl", 32'(ctrl[4]), 32'd1);
        key(1'b0, 9'h014);
        tick(3);
        check("fire1_released", 32'(ctrl[4]), 32'd0);

        // Rotation of joystick up.
        rotate = 1'b1;
        rot_ccw = 1'b0;
        joy[3] = 1'b1;
        tick(3);
        check("rot_cw_up", 32'(ctrl[7:0]), 32'h08);
        rot_ccw = 1'b1;
        tick(3);
        check("rot_ccw_up", 32'(ctrl[7:0]), 32'h04);
        joy[3] = 1'b0;
        rotate = 1'b0;
        rot_ccw = 1'b0;
        tick(3);

        // Held coin: one 4-cycle pulse.
        joy[6] = 1'b1;
        count_coin(0, 20, hi, rs);
        check("coin_held_width", 32'(hi), 32'd4);
        check("coin_held_once", 32'(rs), 32'd1);
        joy[6] = 1'b0;
        tick(12);

        // Re-press during gap is dropped; after the gap it is accepted.
        joy[6] = 1'b1;
        tick(1);
        joy[6] = 1'b0;
        wait_coin(0, 1'b1);
        wait_coin(0, 1'b0);
        seen = 1'b0;
        @(posedge clk_sys); #2 joy[6] = 1'b1;
        @(negedge clk_sys); seen |= coin[0];
        @(posedge clk_sys); #2 joy[6] = 1'b0;
        @(negedge clk_sys); seen |= coin[0];
        @(posedge clk_sys);
        @(negedge clk_sys); seen |= coin[0];
        @(posedge clk_sys); #2 joy[6] = 1'b1;
        @(negedge clk_sys); seen |= coin[0];
        check("coin_gap_drop", 32'(seen), 32'd0);
        count_coin(0, 12, hi, rs);
        check("coin_retrigger_width", 32'(hi), 32'd4);
        joy[6] = 1'b0;
        tick(12);

        // Start key with start_coin.
        start_coin = 1'b1;
        key(1'b1, 9'h01E);
        count_coin(1, 14, hi, rs);
        check("start2_coin_width", 32'(hi), 32'd4);
        check("start2_out", 32'(start[1]), 32'd1);
        key(1'b0, 9'h01E);
        tick(12);
        start_coin = 1'b0;
        key(1'b1, 9'h01E);
        count_coin(1, 14, hi, rs);
        check("start2_no_coin", 32'(hi), 32'd0);
        key(1'b0, 9'h01E);
        tick(12);

        // Asynchronous reset in the middle of a pulse.
        key(1'b1, 9'h036);
        wait_coin(1, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_coin", 32'(coin), 32'd0);
        check("async_rst_ctrl", 32'(ctrl), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(4);
        check("post_rst_coin", 32'(coin), 32'd0);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        begin
            int   last, bad, ntr;
            logic prv;
            joy[9] = 1'b1;
            tick(2);
            last = -1; bad = 0; ntr = 0;
            @(negedge clk_sys);
            prv = ctrl[4];
            for (int i = 1; i < 20; i++) begin
                @(negedge clk_sys);
                if (ctrl[4] !== prv) begin
                    if (last >= 0 && i - last != AF) bad++;
                    last = i;
                    ntr++;
                end
                prv = ctrl[4];
            end
            check("autofire_period", 32'(bad == 0 && ntr >= 4), 32'd1);
            joy[9] = 1'b0;
            tick(2);
        end
`endif

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk_sys);
            #2;
            if ($urandom_range(0, 2) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 26)]};
            if ($urandom_range(0, 4) == 0)
                joy[$urandom_range(0, 16*P-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) rotate = ~rotate;
            if ($urandom_range(0, 19) == 0) rot_ccw = ~rot_ccw;
            if ($urandom_range(0, 19) == 0) start_coin = ~start_coin;
            if ($urandom_range(0, 149) == 0) begin
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
            end
        end
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
